// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state, pc-source and forwarding codes for the hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } state_t;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_J   = 2'b10;
    localparam logic [1:0] PCS_JR  = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] src);
        return (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decoded stage fields in, load enables / selects out
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs, id_use_rt, id_b_instr, id_ta_instr, id_jr, id_br_taken;
    logic             ex_rf_en, mem_rf_en, wb_rf_en, ex_load, mem_load;
    logic             halt_req, step_req, resume_req;
    logic             le_pc, le_npc, le_ifid, le_idex, le_exmem, le_memwb;
    logic             cu_mux_s, halted;
    logic [1:0]       pc_src, fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  id_rs, id_rt, ex_rd, mem_rd, wb_rd,
        input  id_use_rs, id_use_rt, id_b_instr, id_ta_instr, id_jr, id_br_taken,
        input  ex_rf_en, mem_rf_en, wb_rf_en, ex_load, mem_load,
        input  halt_req, step_req, resume_req,
        output le_pc, le_npc, le_ifid, le_idex, le_exmem, le_memwb,
        output cu_mux_s, halted, pc_src, fwd_a, fwd_b, stall_count
    );

    modport master (
        output id_rs, id_rt, ex_rd, mem_rd, wb_rd,
        output id_use_rs, id_use_rt, id_b_instr, id_ta_instr, id_jr, id_br_taken,
        output ex_rf_en, mem_rf_en, wb_rf_en, ex_load, mem_load,
        output halt_req, step_req, resume_req,
        input  le_pc, le_npc, le_ifid, le_idex, le_exmem, le_memwb,
        input  cu_mux_s, halted, pc_src, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// fwd_select: picks the youngest in-flight producer of one EX operand
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_rf_en,
    input  logic       ex_load,
    input  logic       mem_rf_en,
    input  logic       wb_rf_en,
    output logic [1:0] sel
);

    // A load in EX has no data yet, so only non-load EX results are forwardable
    always_comb begin
        sel = (ex_rf_en & ~ex_load & reg_hit(ex_rd, src)) ? FWD_EX  :
              (mem_rf_en & reg_hit(mem_rd, src))          ? FWD_MEM :
              (wb_rf_en & reg_hit(wb_rd, src))            ? FWD_WB  : FWD_RF;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/forward control plus run/halt/step sequencing for the 5-stage pipe
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);

    state_t           state, next;
    logic             ex_hit, mem_hit, lu_hz, br_hz, stall, adv, go;
    logic [1:0]       fwd_a_raw, fwd_b_raw;
    logic [CNT_W-1:0] cnt;

    fwd_select u_fwd_a (
        .src(bus.id_rs), .ex_rd(bus.ex_rd), .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd),
        .ex_rf_en(bus.ex_rf_en), .ex_load(bus.ex_load), .mem_rf_en(bus.mem_rf_en),
        .wb_rf_en(bus.wb_rf_en), .sel(fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .src(bus.id_rt), .ex_rd(bus.ex_rd), .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd),
        .ex_rf_en(bus.ex_rf_en), .ex_load(bus.ex_load), .mem_rf_en(bus.mem_rf_en),
        .wb_rf_en(bus.wb_rf_en), .sel(fwd_b_raw)
    );

    // Hazard detection and per-cycle enables; branches resolve in ID so they also wait on EX/MEM producers
    always_comb begin
        ex_hit  = (bus.id_use_rs & reg_hit(bus.ex_rd, bus.id_rs)) |
                  (bus.id_use_rt & reg_hit(bus.ex_rd, bus.id_rt));
        mem_hit = (bus.id_use_rs & reg_hit(bus.mem_rd, bus.id_rs)) |
                  (bus.id_use_rt & reg_hit(bus.mem_rd, bus.id_rt));
        lu_hz   = bus.ex_load & bus.ex_rf_en & ex_hit;
        br_hz   = (bus.id_b_instr | bus.id_jr) &
                  ((bus.ex_rf_en & ex_hit) | (bus.mem_load & bus.mem_rf_en & mem_hit));
        stall   = lu_hz | br_hz;
        adv     = (state == RUN) || (state == STEP);
        go      = adv & ~stall;
        bus.le_pc       = go;
        bus.le_npc      = go;
        bus.le_ifid     = go;
        bus.le_idex     = adv;
        bus.le_exmem    = adv;
        bus.le_memwb    = adv;
        bus.cu_mux_s    = go | (state == HALT);
        bus.halted      = (state == HALT) || (state == STEP);
        bus.pc_src      = ~go                               ? PCS_SEQ :
                          bus.id_jr                         ? PCS_JR  :
                          bus.id_ta_instr                   ? PCS_J   :
                          (bus.id_b_instr & bus.id_br_taken) ? PCS_BR  : PCS_SEQ;
        bus.fwd_a       = reset ? fwd_a_raw : FWD_RF;
        bus.fwd_b       = reset ? fwd_b_raw : FWD_RF;
        bus.stall_count = cnt;
    end

    // Debug controller next-state: resume beats step in HALT, STEP always lands back in HALT
    always_comb begin
        next = state;
        case (state)
            HOLD:    next = RUN;
            RUN:     next = bus.halt_req ? HALT : RUN;
            HALT:    next = bus.resume_req ? RUN : bus.step_req ? STEP : HALT;
            default: next = HALT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HOLD;
        else        state <= next;
    end

    // Saturating count of advance cycles lost to hazards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    cnt <= '0;
        else if (adv & stall & ~&cnt) cnt <= cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven scoreboard bench for the hazard controller
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [13:0] URS   = 14'h2000;
    localparam logic [13:0] URT   = 14'h1000;
    localparam logic [13:0] BR    = 14'h0800;
    localparam logic [13:0] TA    = 14'h0400;
    localparam logic [13:0] JR    = 14'h0200;
    localparam logic [13:0] TK    = 14'h0100;
    localparam logic [13:0] EXEN  = 14'h0080;
    localparam logic [13:0] MEMEN = 14'h0040;
    localparam logic [13:0] WBEN  = 14'h0020;
    localparam logic [13:0] EXLD  = 14'h0010;
    localparam logic [13:0] MEMLD = 14'h0008;
    localparam logic [13:0] HLT   = 14'h0004;
    localparam logic [13:0] STP   = 14'h0002;
    localparam logic [13:0] RES   = 14'h0001;

    typedef struct packed {
        logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
        logic [13:0] f;
    } in_t;

    typedef struct packed {
        logic [5:0]       le;
        logic             cu;
        logic [1:0]       pc;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             h;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [13:0] f, input int rs = 0, input int rt = 0,
                               input int exrd = 0, input int memrd = 0, input int wbrd = 0);
        in_t r;
        r.id_rs  = 5'(rs);
        r.id_rt  = 5'(rt);
        r.ex_rd  = 5'(exrd);
        r.mem_rd = 5'(memrd);
        r.wb_rd  = 5'(wbrd);
        r.f      = f;
        return r;
    endfunction

    function automatic out_t ex(input int le, input int cu, input int pc, input int fa,
                                input int fb, input int h, input int c);
        out_t r;
        r.le  = 6'(le);
        r.cu  = 1'(cu);
        r.pc  = 2'(pc);
        r.fa  = 2'(fa);
        r.fb  = 2'(fb);
        r.h   = 1'(h);
        r.cnt = CNT_W'(c);
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.le  = {bus.le_pc, bus.le_npc, bus.le_ifid, bus.le_idex, bus.le_exmem, bus.le_memwb};
        r.cu  = bus.cu_mux_s;
        r.pc  = bus.pc_src;
        r.fa  = bus.fwd_a;
        r.fb  = bus.fwd_b;
        r.h   = bus.halted;
        r.cnt = bus.stall_count;
        return r;
    endfunction

    task automatic drive(input in_t v);
        bus.id_rs       = v.id_rs;
        bus.id_rt       = v.id_rt;
        bus.ex_rd       = v.ex_rd;
        bus.mem_rd      = v.mem_rd;
        bus.wb_rd       = v.wb_rd;
        bus.id_use_rs   = v.f[13];
        bus.id_use_rt   = v.f[12];
        bus.id_b_instr  = v.f[11];
        bus.id_ta_instr = v.f[10];
        bus.id_jr       = v.f[9];
        bus.id_br_taken = v.f[8];
        bus.ex_rf_en    = v.f[7];
        bus.mem_rf_en   = v.f[6];
        bus.wb_rf_en    = v.f[5];
        bus.ex_load     = v.f[4];
        bus.mem_load    = v.f[3];
        bus.halt_req    = v.f[2];
        bus.step_req    = v.f[1];
        bus.resume_req  = v.f[0];
    endtask

    task automatic compare(input string name);
        out_t g, e;
        g = sample();
        e = exp_q.pop_front();
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got le=%b cu=%b pc=%b fa=%b fb=%b h=%b cnt=%0d, need le=%b cu=%b pc=%b fa=%b fb=%b h=%b cnt=%0d",
                     name, g.le, g.cu, g.pc, g.fa, g.fb, g.h, g.cnt,
                     e.le, e.cu, e.pc, e.fa, e.fb, e.h, e.cnt);
        end
    endtask

    task automatic check(input in_t i, input out_t o, input string name);
        drive(i);
        exp_q.push_back(o);
        @(negedge clk);
        compare(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(mk(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        compare("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        tbl.push_back('{mk(0), ex(0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk(0), ex(63, 1, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk(URS|EXEN|EXLD, 5, 0, 5), ex(7, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{mk(URS|MEMEN|MEMLD, 5, 0, 0, 5), ex(63, 1, 0, 2, 0, 0, 1)});
        tbl.push_back('{mk(URS|BR|TK|EXEN|EXLD, 8, 0, 8), ex(7, 0, 0, 0, 0, 0, 1)});
        tbl.push_back('{mk(URS|BR|TK|MEMEN|MEMLD, 8, 0, 0, 8), ex(7, 0, 0, 2, 0, 0, 2)});
        tbl.push_back('{mk(URS|BR|TK|WBEN, 8, 0, 0, 0, 8), ex(63, 1, 1, 3, 0, 0, 3)});
        tbl.push_back('{mk(URT|EXEN|MEMEN|WBEN, 0, 3, 3, 3, 3), ex(63, 1, 0, 0, 1, 0, 3)});
        tbl.push_back('{mk(URT|EXEN|MEMEN|WBEN, 0, 3, 0, 3, 3), ex(63, 1, 0, 0, 2, 0, 3)});
        tbl.push_back('{mk(URT|EXEN|MEMEN|WBEN, 0, 0, 0, 0, 0), ex(63, 1, 0, 0, 0, 0, 3)});
        tbl.push_back('{mk(JR|TA|BR|TK), ex(63, 1, 3, 0, 0, 0, 3)});
        tbl.push_back('{mk(TA|BR|TK), ex(63, 1, 2, 0, 0, 0, 3)});
        tbl.push_back('{mk(BR), ex(63, 1, 0, 0, 0, 0, 3)});
        tbl.push_back('{mk(URS|EXEN|EXLD, 0, 0, 0), ex(63, 1, 0, 0, 0, 0, 3)});
        tbl.push_back('{mk(URS|JR|EXEN, 4, 0, 4), ex(7, 0, 0, 1, 0, 0, 3)});
        tbl.push_back('{mk(HLT), ex(63, 1, 0, 0, 0, 0, 4)});
        tbl.push_back('{mk(URS|URT|EXEN|EXLD|MEMEN, 5, 6, 5, 6), ex(0, 1, 0, 0, 2, 1, 4)});
        tbl.push_back('{mk(HLT), ex(0, 1, 0, 0, 0, 1, 4)});
        for (int k = 0; k < 8; k++) tbl.push_back('{mk(0), ex(0, 1, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(STP), ex(0, 1, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(0), ex(63, 1, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(0), ex(0, 1, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(STP), ex(0, 1, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(URS|EXEN|EXLD|RES, 5, 0, 5), ex(7, 0, 0, 0, 0, 1, 4)});
        tbl.push_back('{mk(0), ex(0, 1, 0, 0, 0, 1, 5)});
        tbl.push_back('{mk(RES|STP), ex(0, 1, 0, 0, 0, 1, 5)});
        tbl.push_back('{mk(STP|RES), ex(63, 1, 0, 0, 0, 0, 5)});
        tbl.push_back('{mk(HLT), ex(63, 1, 0, 0, 0, 0, 5)});
        tbl.push_back('{mk(STP), ex(0, 1, 0, 0, 0, 1, 5)});

        foreach (tbl[k]) check(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

        drive(mk(URS|EXEN, 3, 0, 3));
        #1 reset = 1'b0;
        #1 exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        compare("reset_in_step");
        @(posedge clk);
        #1 reset = 1'b1;
        check(mk(0), ex(0, 0, 0, 0, 0, 0, 0), "hold_after_reset");
        check(mk(0), ex(63, 1, 0, 0, 0, 0, 0), "run_after_reset");

        for (int k = 0; k < 18; k++)
            check(mk(URS|EXEN|EXLD, 5, 0, 5), ex(7, 0, 0, 0, 0, 0, k < 15 ? k : 15), $sformatf("sat%0d", k));
        check(mk(0), ex(63, 1, 0, 0, 0, 0, 15), "sat_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB): drives PC/nPC and pipeline-register load enables, the control-unit bubble select and the PC source select.
- Generates operand-forwarding selects for the EX stage.
- Provides a run/halt/single-step controller for debug and bring-up.
- Sits beside the control unit; consumes decoded register fields and per-stage RF_Enable/Load_Instr bits.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous active-low reset; asserted when 0.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- id_b_instr  in  1  conditional branch in ID (ID_B_Instr).
- id_ta_instr  in  1  jump/JAL in ID (ID_TA_Instr).
- id_jr  in  1  JR in ID.
- id_br_taken  in  1  branch condition true (valid with id_b_instr).
- ex_rd, mem_rd, wb_rd  in  5 each  destination register per stage.
- ex_rf_en, mem_rf_en, wb_rf_en  in  1 each  stage writes RF.
- ex_load, mem_load  in  1 each  stage holds a load.
- halt_req, step_req, resume_req  in  1 each  debug commands, one-cycle pulses.
- le_pc, le_npc, le_ifid  out  1 each  load enables, front end.
- le_idex, le_exmem, le_memwb  out  1 each  load enables, back end.
- cu_mux_s  out  1  1 = pass control word, 0 = inject bubble (all-zero control).
- pc_src  out  2  00 nPC+4, 01 branch target, 10 jump target, 11 JR register.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 RF, 01 EX/MEM, 10 MEM/WB, 11 WB-latch.
- halted  out  1  controller is in HALT.
- stall_count  out  CNT_W  hazard stall cycles since reset.

Behaviour:
- Reset (reset=0): state=HOLD, stall_count=0. All le_* = 0, cu_mux_s=0, pc_src=00, fwd_*=00, halted=0.
- Register 0 never matches a hazard or forward.
- Hazard conditions:
  - lu_hz: ex_load & ex_rf_en & ex_rd matches a used ID source.
  - br_hz: (id_b_instr|id_jr) and a used source matches ex_rd with ex_rf_en, or mem_rd with mem_load & mem_rf_en.
  - stall = lu_hz | br_hz.
  - A 2-cycle branch-on-load stall falls out naturally: EX match, then MEM-load match.
- Advance cycle (RUN, or the step cycle):
  - With stall: le_pc = le_npc = le_ifid = 0, cu_mux_s=0; le_idex, le_exmem, le_memwb = 1; pc_src=00; stall_count += 1, saturating at all-ones.
  - Without stall: all le_* = 1, cu_mux_s=1.
  - pc_src priority: id_jr -> 11, id_ta_instr -> 10, id_b_instr & id_br_taken -> 01, else 00.
  - Delay-slot architecture: no flush on taken branch or jump.
- Forwarding per operand, priority EX > MEM > WB:
  - 01 if ex_rf_en & !ex_load & ex_rd == src.
  - else 10 if mem_rf_en & mem_rd == src.
  - else 11 if wb_rf_en & wb_rd == src.
  - else 00.
  - Combinational in every state.
- FSM states: HOLD, RUN, HALT, STEP.
  - HOLD: one cycle after reset release; all le_* = 0, cu_mux_s=0; PC stays 0, nPC stays 4. Next state RUN.
  - RUN: advance cycle. halt_req -> HALT at the next edge; the current cycle still advances.
  - HALT: all le_* = 0, cu_mux_s=1 (pipeline frozen, no bubble), halted=1, stall_count unchanged.
    - resume_req -> RUN.
    - else step_req -> STEP.
    - resume_req has priority over step_req.
  - STEP: exactly one advance cycle with full hazard rules, halted=1, then HALT. A stall during STEP consumes the step; the next step retries.
  - halt_req in HALT/STEP is ignored. step_req/resume_req in RUN are ignored.
- Reset asserted in any state returns to HOLD immediately; outputs go to reset values without waiting for clk.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (HOLD=0, RUN=1, HALT=2, STEP=3);
  - pc_src codes PCS_SEQ/PCS_BR/PCS_J/PCS_JR;
  - forward codes FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
- One natural sub-module, fwd_select: purely combinational, instantiated twice (operand A, operand B).

Test Plan:
- Reset then release -> cycle 1: HOLD, all le_*=0. Cycle 2: RUN, all le_*=1, cu_mux_s=1, stall_count=0.
- ex_load=1, ex_rf_en=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle of le_pc=le_ifid=0, cu_mux_s=0, stall_count=1. Next cycle (load moved to MEM, ex_load=0) -> fwd_a=10, no stall.
- id_b_instr=1, id_br_taken=1, id_rs=8 dependent on EX load rd=8 -> two stall cycles (stall_count=2), then pc_src=01 with le_pc=1.
- ex_rd=mem_rd=wb_rd=3 all rf_en, id_rt=3 -> fwd_b=01. With ex_rd=0 instead -> fwd_b=10. Any rd=0 source -> 00.
- halt_req in RUN -> next edge halted=1, all le_*=0, for 10 cycles. step_req -> exactly one cycle with le_*=1, then frozen again. resume_req+step_req same cycle -> RUN.
- Assert reset during STEP -> outputs zero immediately, stall_count=0. After release -> HOLD then RUN.
